// File: rtl/key_pkg.sv
// Shared constants, hold-FSM state type and counter width helper for the
// multi-key debouncer.
package key_pkg;

    localparam int unsigned CNT_MAX_DEF    = 1_000_000;
    localparam int unsigned LONG_MAX_DEF   = 50_000_000;
    localparam int unsigned REPEAT_MAX_DEF = 10_000_000;

    typedef enum logic {
        HOLD   = 1'b0,
        REPEAT = 1'b1
    } hold_state_e;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounced key channel: synchroniser, stability counter, press/release
// pulses and, when KEY_LONG_PRESS_EN is defined, the long-press/repeat FSM.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
    parameter int unsigned LONG_MAX   = LONG_MAX_DEF,
    parameter int unsigned REPEAT_MAX = REPEAT_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic key_filtered,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned CW = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] CNT_LOAD = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync0_q, sync1_q, sync1d_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          chg;

    assign chg = sync1_q ^ sync1d_q;

    // The level is accepted only after a full quiet window; any glitch reloads.
    always_comb begin
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (chg) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        if (!chg && cnt_q == CNT_ONE) begin
            filt_d  = sync1_q;
            press_d = filt_q & ~sync1_q;
            rel_d   = ~filt_q & sync1_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync0_q  <= 1'b1;
            sync1_q  <= 1'b1;
            sync1d_q <= 1'b1;
            cnt_q    <= '0;
            filt_q   <= 1'b1;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync0_q  <= key;
            sync1_q  <= sync0_q;
            sync1d_q <= sync1_q;
            cnt_q    <= cnt_d;
            filt_q   <= filt_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
        end
    end

    assign key_filtered = filt_q;
    assign key_press    = press_q;
    assign key_release  = rel_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned HW = cnt_width(max_u(LONG_MAX, REPEAT_MAX));
    localparam logic [HW-1:0] LONG_LAST = (LONG_MAX == 0) ? '0 : HW'(LONG_MAX - 1);
    localparam logic [HW-1:0] REP_LAST  = (REPEAT_MAX == 0) ? '0 : HW'(REPEAT_MAX - 1);

    hold_state_e   state_q;
    logic [HW-1:0] hcnt_q;
    logic          long_q;

    // A release being accepted this edge also clears, so no pulse lands on it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= HOLD;
            hcnt_q  <= '0;
            long_q  <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (filt_q || rel_d) begin
                hcnt_q  <= '0;
                state_q <= HOLD;
            end else begin
                case (state_q)
                    HOLD: begin
                        if (hcnt_q == LONG_LAST) begin
                            long_q  <= 1'b1;
                            hcnt_q  <= '0;
                            state_q <= REPEAT;
                        end else begin
                            hcnt_q <= hcnt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (REPEAT_MAX != 0) begin
                            if (hcnt_q == REP_LAST) begin
                                long_q <= 1'b1;
                                hcnt_q <= '0;
                            end else begin
                                hcnt_q <= hcnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= HOLD;
                endcase
            end
        end
    end

    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/multi_key_debounce.sv
// N-channel active-low push-button debouncer; long-press/auto-repeat is
// compiled in when KEY_LONG_PRESS_EN is defined.
module multi_key_debounce
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS     = 4,
    parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
    parameter int unsigned LONG_MAX   = LONG_MAX_DEF,
    parameter int unsigned REPEAT_MAX = REPEAT_MAX_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_filtered,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              key_any
);

    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_chan
        key_debounce_chan #(
            .CNT_MAX    (CNT_MAX),
            .LONG_MAX   (LONG_MAX),
            .REPEAT_MAX (REPEAT_MAX)
        ) u_chan (
            .sys_clk      (sys_clk),
            .sys_rst      (sys_rst),
            .key          (key[i]),
            .key_filtered (key_filtered[i]),
            .key_press    (key_press[i]),
            .key_release  (key_release[i]),
            .key_long     (key_long[i])
        );
    end

    // Keys are active-low, so "any pressed" means "not all ones".
    assign key_any = ~&key_filtered;

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed table-driven bench for multi_key_debounce (N_KEYS=4, CNT_MAX=10).
module tb_multi_key_debounce;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] key = 4'b1111;
    logic [3:0] key_filtered, key_press, key_release, key_long;
    logic       key_any;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    multi_key_debounce #(
        .N_KEYS     (4),
        .CNT_MAX    (10),
        .LONG_MAX   (50),
        .REPEAT_MAX (20)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key          (key),
        .key_filtered (key_filtered),
        .key_press    (key_press),
        .key_release  (key_release),
        .key_long     (key_long),
        .key_any      (key_any)
    );

    typedef struct {
        logic [3:0] key;
        int         steps;
        logic [3:0] filt;
        logic [3:0] press;
        logic [3:0] rel;
        logic       any;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] f, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] l, input logic a);
        chk({name, ".filt"},  32'(key_filtered), 32'(f));
        chk({name, ".press"}, 32'(key_press),    32'(p));
        chk({name, ".rel"},   32'(key_release),  32'(r));
        chk({name, ".long"},  32'(key_long),     32'(l));
        chk({name, ".any"},   32'(key_any),      32'(a));
    endtask

    task automatic release_all();
        key = 4'b1111;
        repeat (12) step();
        step();
        chk("release_all.filt", 32'(key_filtered), 32'hf);
        step();
    endtask

    initial begin
        // record: key, steps, filt, press, rel, any
        tbl.push_back('{4'b0000, 12, 4'hf, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'b0000,  1, 4'h0, 4'hf, 4'h0, 1'b1});
        tbl.push_back('{4'b0000,  1, 4'h0, 4'h0, 4'h0, 1'b1});
        tbl.push_back('{4'b1111, 12, 4'h0, 4'h0, 4'h0, 1'b1});
        tbl.push_back('{4'b1111,  1, 4'hf, 4'h0, 4'hf, 1'b0});
        tbl.push_back('{4'b1111,  1, 4'hf, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'b1110, 12, 4'hf, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'b1110,  1, 4'he, 4'h1, 4'h0, 1'b1});
        tbl.push_back('{4'b1110,  1, 4'he, 4'h0, 4'h0, 1'b1});
        tbl.push_back('{4'b1111, 12, 4'he, 4'h0, 4'h0, 1'b1});
        tbl.push_back('{4'b1111,  1, 4'hf, 4'h0, 4'h1, 1'b0});
        tbl.push_back('{4'b1111,  1, 4'hf, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'b0011, 12, 4'hf, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'b0011,  1, 4'h3, 4'hc, 4'h0, 1'b1});
        tbl.push_back('{4'b0011,  5, 4'h3, 4'h0, 4'h0, 1'b1});
        tbl.push_back('{4'b1111, 12, 4'h3, 4'h0, 4'h0, 1'b1});
        tbl.push_back('{4'b1111,  1, 4'hf, 4'h0, 4'hc, 1'b0});
        tbl.push_back('{4'b1111,  1, 4'hf, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'b1011,  3, 4'hf, 4'h0, 4'h0, 1'b0});
        tbl.push_back('{4'b1111, 20, 4'hf, 4'h0, 4'h0, 1'b0});

        // Reset with every key held down.
        key = 4'b0000;
        sys_rst = 1'b1;
        repeat (3) step();
        chk_all("reset", 4'hf, 4'h0, 4'h0, 4'h0, 1'b0);
        sys_rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            key = tbl[i].key;
            repeat (tbl[i].steps) step();
            chk_all($sformatf("vec%0d", i), tbl[i].filt, tbl[i].press, tbl[i].rel, 4'h0, tbl[i].any);
        end

        // Bounce on key[1]: 4-cycle toggles never accepted, then stays low.
        for (int seg = 0; seg < 10; seg++) begin
            key = (seg % 2 == 0) ? 4'b1101 : 4'b1111;
            for (int c = 0; c < 4; c++) begin
                step();
                chk("bounce.quiet", {29'd0, key_filtered[1], key_press[1], key_release[1]}, 32'b100);
            end
        end
        key = 4'b1101;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("bounce.settle", {29'd0, key_filtered[1], key_press[1], key_release[1]}, 32'b100);
        end
        step();
        chk("bounce.press", 32'(key_press), 32'h2);
        chk("bounce.filt", 32'(key_filtered), 32'hd);
        step();
        chk("bounce.press_end", 32'(key_press), 32'h0);
        release_all();

        // Reset in the middle of a count, key still held afterwards.
        key = 4'b1101;
        repeat (6) step();
        sys_rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            chk_all("midreset", 4'hf, 4'h0, 4'h0, 4'h0, 1'b0);
        end
        sys_rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("midreset.wait", {28'd0, key_press}, 32'h0);
        end
        step();
        chk("midreset.press", 32'(key_press), 32'h2);
        step();
        chk("midreset.press_end", 32'(key_press), 32'h0);
        release_all();

        // Long press and auto-repeat on key[0]; pin released after P+110.
        key = 4'b1110;
        repeat (12) step();
        step();
        chk("long.press", 32'(key_press), 32'h1);
        for (int c = 1; c <= 140; c++) begin
            logic [3:0] exp_long;
            exp_long = 4'h0;
`ifdef KEY_LONG_PRESS_EN
            if (c == 50 || c == 70 || c == 90 || c == 110) exp_long = 4'h1;
`endif
            step();
            chk($sformatf("long.c%0d", c), 32'(key_long), 32'(exp_long));
            chk($sformatf("long.rel%0d", c), 32'(key_release), (c == 123) ? 32'h1 : 32'h0);
            chk($sformatf("long.filt%0d", c), 32'(key_filtered), (c >= 123) ? 32'hf : 32'he);
            if (c == 110) key = 4'b1111;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
